// File: rtl/spram_req_adapter.sv
`default_nettype none
// ============================================================================
// Module   : spram_req_adapter
// Function : valid/grant request front-end for a single-port 64-bit byte-enable
//            RAM, with credit-protected in-order response FIFO (valid/ready).
// Revision : 1.0 - initial release
// ============================================================================
module spram_req_adapter #(
    parameter int ADDR_WIDTH = 10,
    parameter int RAM_LAT    = 1,
    parameter int RESP_DEPTH = 4
) (
    input  logic                  Clk_CI,
    input  logic                  Rst_RBI,
    input  logic                  Req_SI,
    output logic                  Gnt_SO,
    input  logic                  ReqWe_SI,
    input  logic [7:0]            ReqBe_SI,
    input  logic [ADDR_WIDTH-1:0] ReqAddr_DI,
    input  logic [63:0]           ReqWData_DI,
    output logic                  RspValid_SO,
    input  logic                  RspReady_SI,
    output logic                  RspWrite_SO,
    output logic [63:0]           RspRData_DO,
    output logic                  RamCSel_SO,
    output logic                  RamWrEn_SO,
    output logic [7:0]            RamBEn_SO,
    output logic [ADDR_WIDTH-1:0] RamAddr_DO,
    output logic [63:0]           RamWrData_DO,
    input  logic [63:0]           RamRdData_DI
);

    localparam int c_CNT_W = $clog2(RESP_DEPTH + 1);
    localparam int c_PTR_W = $clog2(RESP_DEPTH);

    localparam logic [c_CNT_W-1:0] c_DEPTH    = c_CNT_W'(RESP_DEPTH);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE  = c_PTR_W'(1);
    localparam logic [c_PTR_W-1:0] c_LAST_PTR = c_PTR_W'(RESP_DEPTH - 1);

    logic [c_CNT_W-1:0] credits_q, credits_d;
    logic [RAM_LAT-1:0] tag_vld_q, tag_vld_d;
    logic [RAM_LAT-1:0] tag_wr_q,  tag_wr_d;
    logic [c_PTR_W-1:0] wptr_q, wptr_d;
    logic [c_PTR_W-1:0] rptr_q, rptr_d;
    logic [c_CNT_W-1:0] count_q, count_d;
    logic [64:0]        fifo_q [RESP_DEPTH];

    logic               w_accept;
    logic               w_pop;
    logic               w_push;
    logic [64:0]        w_push_data;
    logic [64:0]        w_head;

    // Grant depends only on registered credits, so the response ready never
    // reaches the request side or the RAM pins combinationally.
    assign Gnt_SO   = (credits_q != '0) && Rst_RBI;
    assign w_accept = Req_SI && Gnt_SO;

    assign RamCSel_SO   = w_accept;
    assign RamWrEn_SO   = ReqWe_SI && w_accept;
    assign RamBEn_SO    = w_accept ? ReqBe_SI : 8'h00;
    assign RamAddr_DO   = ReqAddr_DI;
    assign RamWrData_DO = ReqWData_DI;

    assign RspValid_SO = (count_q != '0);
    assign w_pop       = RspValid_SO && RspReady_SI;
    assign w_head      = fifo_q[rptr_q];
    assign RspWrite_SO = RspValid_SO && w_head[64];
    assign RspRData_DO = RspValid_SO ? w_head[63:0] : 64'h0;

    always_comb begin
        credits_d = credits_q;
        if (w_accept && !w_pop) begin
            credits_d = credits_q - c_CNT_ONE;
        end else if (!w_accept && w_pop) begin
            credits_d = credits_q + c_CNT_ONE;
        end
    end

    // Tag pipeline: the last stage lines up with the RAM read data.
    assign tag_vld_d[0] = w_accept;
    assign tag_wr_d[0]  = w_accept && ReqWe_SI;

    generate
        for (genvar i = 1; i < RAM_LAT; i++) begin : g_tag_stage
            assign tag_vld_d[i] = tag_vld_q[i-1];
            assign tag_wr_d[i]  = tag_wr_q[i-1];
        end
    endgenerate

    assign w_push      = tag_vld_q[RAM_LAT-1];
    assign w_push_data = {tag_wr_q[RAM_LAT-1],
                          tag_wr_q[RAM_LAT-1] ? 64'h0 : RamRdData_DI};

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (w_push) begin
            wptr_d = (wptr_q == c_LAST_PTR) ? '0 : wptr_q + c_PTR_ONE;
        end
        if (w_pop) begin
            rptr_d = (rptr_q == c_LAST_PTR) ? '0 : rptr_q + c_PTR_ONE;
        end
        if (w_push && !w_pop) begin
            count_d = count_q + c_CNT_ONE;
        end else if (!w_push && w_pop) begin
            count_d = count_q - c_CNT_ONE;
        end
    end

    always_ff @(posedge Clk_CI) begin
        if (!Rst_RBI) begin
            credits_q <= c_DEPTH;
            tag_vld_q <= '0;
            tag_wr_q  <= '0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
        end else begin
            credits_q <= credits_d;
            tag_vld_q <= tag_vld_d;
            tag_wr_q  <= tag_wr_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            count_q   <= count_d;
        end
    end

    // Storage is left unreset; the head is masked while the FIFO is empty.
    always_ff @(posedge Clk_CI) begin
        if (w_push) begin
            fifo_q[wptr_q] <= w_push_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spram_req_adapter.sv
`default_nettype none
// ============================================================================
// Module   : tb_spram_req_adapter
// Function : directed self-checking bench; DUT A (RAM_LAT=1, depth 2) and
//            DUT B (RAM_LAT=2, depth 4), each with a behavioural RAM.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spram_req_adapter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstA_n, reqA, gntA, weA, rvA, rrA, rwA, csA, wenA;
    logic [7:0]  beA, benA;
    logic [9:0]  addrA, raddrA;
    logic [63:0] wdA, rdA, rwdA, ramrdA;

    logic        rstB_n, reqB, gntB, weB, rvB, rrB, rwB, csB, wenB;
    logic [7:0]  beB, benB;
    logic [9:0]  addrB, raddrB;
    logic [63:0] wdB, rdB, rwdB, ramrdB, ramq1B;

    logic [63:0] memA [1024];

    int nvec = 0;
    int nerr = 0;
    int outA = 0;
    int outB = 0;
    int nresp;

    spram_req_adapter #(.ADDR_WIDTH(10), .RAM_LAT(1), .RESP_DEPTH(2)) u_dut_a (
        .Clk_CI(clk), .Rst_RBI(rstA_n), .Req_SI(reqA), .Gnt_SO(gntA),
        .ReqWe_SI(weA), .ReqBe_SI(beA), .ReqAddr_DI(addrA), .ReqWData_DI(wdA),
        .RspValid_SO(rvA), .RspReady_SI(rrA), .RspWrite_SO(rwA), .RspRData_DO(rdA),
        .RamCSel_SO(csA), .RamWrEn_SO(wenA), .RamBEn_SO(benA), .RamAddr_DO(raddrA),
        .RamWrData_DO(rwdA), .RamRdData_DI(ramrdA)
    );

    spram_req_adapter #(.ADDR_WIDTH(10), .RAM_LAT(2), .RESP_DEPTH(4)) u_dut_b (
        .Clk_CI(clk), .Rst_RBI(rstB_n), .Req_SI(reqB), .Gnt_SO(gntB),
        .ReqWe_SI(weB), .ReqBe_SI(beB), .ReqAddr_DI(addrB), .ReqWData_DI(wdB),
        .RspValid_SO(rvB), .RspReady_SI(rrB), .RspWrite_SO(rwB), .RspRData_DO(rdB),
        .RamCSel_SO(csB), .RamWrEn_SO(wenB), .RamBEn_SO(benB), .RamAddr_DO(raddrB),
        .RamWrData_DO(rwdB), .RamRdData_DI(ramrdB)
    );

    // Read-only contents of RAM B, a fixed function of the address.
    function automatic logic [63:0] patB(input logic [9:0] a);
        return {16'hBEEF, 6'h0, a, 16'h1234, 6'h0, a};
    endfunction

    always @(posedge clk) begin
        if (csA) begin
            if (wenA) begin
                for (int b = 0; b < 8; b++) begin
                    if (benA[b]) memA[raddrA][8*b +: 8] <= rwdA[8*b +: 8];
                end
            end else begin
                ramrdA <= memA[raddrA];
            end
        end
    end

    always @(posedge clk) begin
        if (csB && !wenB) ramq1B <= patB(raddrB);
        ramrdB <= ramq1B;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        chk(tag, {63'd0, obs}, {63'd0, exp});
    endtask

    // Per-cycle port-level credit bookkeeping, then advance one clock.
    task automatic cyc();
        if (rstA_n) chk1("gntA_credit", gntA, outA < 2);
        if (rstB_n) chk1("gntB_credit", gntB, outB < 4);
        if (!rstA_n) outA = 0;
        else outA = outA + int'(reqA && gntA) - int'(rvA && rrA);
        if (!rstB_n) outB = 0;
        else outB = outB + int'(reqB && gntB) - int'(rvB && rrB);
        chk1("outA_range", (outA >= 0) && (outA <= 2), 1'b1);
        chk1("outB_range", (outB >= 0) && (outB <= 4), 1'b1);
        @(posedge clk);
        #1;
    endtask

    task automatic drvA(input logic r, input logic we, input logic [7:0] be,
                        input logic [9:0] a, input logic [63:0] d, input logic rr);
        reqA = r; weA = we; beA = be; addrA = a; wdA = d; rrA = rr;
    endtask

    task automatic drvB(input logic r, input logic [9:0] a, input logic rr);
        reqB = r; addrB = a; rrB = rr;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        weB = 1'b0; beB = 8'hA5; wdB = 64'h5555_AAAA_5555_AAAA;
        rstA_n = 1'b0; rstB_n = 1'b0;
        drvA(1'b1, 1'b1, 8'hFF, 10'd3, 64'hDEAD_BEEF_0000_0001, 1'b0);
        drvB(1'b1, 10'd7, 1'b0);
        #1;
        cyc();
        // Still in reset: grant and RAM strobes masked, response side empty.
        chk1("rst_gntA", gntA, 1'b0);
        chk1("rst_csA", csA, 1'b0);
        chk1("rst_wenA", wenA, 1'b0);
        chk("rst_benA", {56'd0, benA}, 64'd0);
        chk("rst_raddrA", {54'd0, raddrA}, 64'd3);
        chk1("rst_rvA", rvA, 1'b0);
        chk1("rst_rwA", rwA, 1'b0);
        chk("rst_rdA", rdA, 64'd0);
        chk1("rst_gntB", gntB, 1'b0);
        chk1("rst_csB", csB, 1'b0);
        chk1("rst_rvB", rvB, 1'b0);
        chk("rst_benB", {56'd0, benB}, 64'd0);
        chk("rst_rwdB", rwdB, 64'h5555_AAAA_5555_AAAA);
        cyc();
        rstA_n = 1'b1; rstB_n = 1'b1;
        drvA(1'b0, 1'b0, 8'h00, 10'd0, 64'd0, 1'b1);
        drvB(1'b0, 10'd0, 1'b1);
        #1;
        chk1("post_rst_gntA", gntA, 1'b1);
        chk1("post_rst_gntB", gntB, 1'b1);
        chk1("post_rst_rvB", rvB, 1'b0);
        cyc();

        // ---- A: full write then read of addr 5 ----
        drvA(1'b1, 1'b1, 8'hFF, 10'd5, 64'h0123_4567_89AB_CDEF, 1'b1);
        #1;
        chk1("wr_gnt", gntA, 1'b1);
        chk1("wr_cs", csA, 1'b1);
        chk1("wr_wen", wenA, 1'b1);
        chk("wr_ben", {56'd0, benA}, 64'hFF);
        chk("wr_wdata", rwdA, 64'h0123_4567_89AB_CDEF);
        cyc();
        drvA(1'b1, 1'b0, 8'h00, 10'd5, 64'd0, 1'b1);
        #1;
        chk1("rd_cs", csA, 1'b1);
        chk1("rd_wen", wenA, 1'b0);
        chk1("rd_rv_early", rvA, 1'b0);
        cyc();
        drvA(1'b0, 1'b0, 8'hFF, 10'd0, 64'd0, 1'b1);
        #1;
        chk1("idle_cs", csA, 1'b0);
        chk("idle_ben", {56'd0, benA}, 64'd0);
        chk1("wack_rv", rvA, 1'b1);
        chk1("wack_rw", rwA, 1'b1);
        chk("wack_rd", rdA, 64'd0);
        cyc();
        #1;
        chk1("rdrsp_rv", rvA, 1'b1);
        chk1("rdrsp_rw", rwA, 1'b0);
        chk("rdrsp_rd", rdA, 64'h0123_4567_89AB_CDEF);
        cyc();

        // ---- A: partial write (low 4 bytes) then read ----
        drvA(1'b1, 1'b1, 8'h0F, 10'd5, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        #1;
        chk1("pw_rv_idle", rvA, 1'b0);
        cyc();
        drvA(1'b1, 1'b0, 8'h00, 10'd5, 64'd0, 1'b1);
        #1;
        cyc();
        drvA(1'b0, 1'b0, 8'h00, 10'd0, 64'd0, 1'b1);
        #1;
        chk1("pw_ack_rw", rwA, 1'b1);
        cyc();
        #1;
        chk1("pw_rd_rv", rvA, 1'b1);
        chk("pw_rd_data", rdA, 64'h0123_4567_FFFF_FFFF);
        cyc();
        #1;
        chk1("pw_drained", rvA, 1'b0);

        // ---- A (depth 2): fill, stall, then accept together with a pop ----
        drvA(1'b1, 1'b0, 8'h00, 10'd5, 64'd0, 1'b0);
        #1;
        cyc();
        drvA(1'b1, 1'b1, 8'hFF, 10'd6, 64'h1111_2222_3333_4444, 1'b0);
        #1;
        chk1("f_gnt_last", gntA, 1'b1);
        cyc();
        drvA(1'b1, 1'b0, 8'h00, 10'd6, 64'd0, 1'b0);
        #1;
        chk1("f_nognt", gntA, 1'b0);
        chk1("f_nocs", csA, 1'b0);
        chk1("f_rv1", rvA, 1'b1);
        cyc();
        rrA = 1'b1;
        #1;
        chk1("f_full_gnt", gntA, 1'b0);
        chk1("f_head_rw", rwA, 1'b0);
        chk("f_head_rd", rdA, 64'h0123_4567_FFFF_FFFF);
        cyc();
        #1;
        chk1("f_regnt", gntA, 1'b1);
        chk1("f_wack_rw", rwA, 1'b1);
        chk("f_wack_rd", rdA, 64'd0);
        cyc();
        drvA(1'b0, 1'b0, 8'h00, 10'd0, 64'd0, 1'b1);
        #1;
        chk1("f_credit_kept", gntA, 1'b1);
        chk1("f_gap", rvA, 1'b0);
        cyc();
        #1;
        chk1("f_last_rv", rvA, 1'b1);
        chk("f_last_rd", rdA, 64'h1111_2222_3333_4444);
        cyc();
        #1;
        chk1("f_empty", rvA, 1'b0);

        // ---- B: backpressure, exactly 4 grants ----
        for (int k = 0; k < 4; k++) begin
            drvB(1'b1, 10'(10 + k), 1'b0);
            #1;
            chk1("bp_gnt", gntB, 1'b1);
            cyc();
        end
        for (int k = 0; k < 4; k++) begin
            drvB(1'b1, 10'd14, 1'b0);
            #1;
            chk1("bp_stall_gnt", gntB, 1'b0);
            chk1("bp_stall_cs", csB, 1'b0);
            cyc();
        end
        drvB(1'b1, 10'd14, 1'b1);
        #1;
        chk1("bp_pop_gnt", gntB, 1'b0);
        chk1("bp_rv0", rvB, 1'b1);
        chk("bp_rd0", rdB, patB(10'd10));
        cyc();
        #1;
        chk1("bp_regnt", gntB, 1'b1);
        chk("bp_rd1", rdB, patB(10'd11));
        cyc();
        for (int k = 2; k < 5; k++) begin
            drvB(1'b0, 10'd0, 1'b1);
            #1;
            chk1("bp_rv", rvB, 1'b1);
            chk("bp_rd", rdB, patB(10'(10 + k)));
            cyc();
        end
        #1;
        chk1("bp_drained", rvB, 1'b0);

        // ---- B: 100 back-to-back reads ----
        nresp = 0;
        for (int c = 0; c < 104; c++) begin
            if (c < 100) drvB(1'b1, 10'(c), 1'b1);
            else drvB(1'b0, 10'd0, 1'b1);
            #1;
            if (c < 100) chk1("st_gnt", gntB, 1'b1);
            if (c >= 3 && c < 103) begin
                chk1("st_rv", rvB, 1'b1);
                chk("st_rd", rdB, patB(10'(c - 3)));
            end else begin
                chk1("st_idle", rvB, 1'b0);
            end
            if (rvB) nresp++;
            cyc();
        end
        chk("st_count", 64'(nresp), 64'd100);

        // ---- B: reset with 2 reads in flight and 1 response queued ----
        for (int k = 0; k < 3; k++) begin
            drvB(1'b1, 10'(20 + k), 1'b0);
            #1;
            cyc();
        end
        drvB(1'b1, 10'd23, 1'b0);
        rstB_n = 1'b0;
        #1;
        chk1("mr_gnt", gntB, 1'b0);
        chk1("mr_cs", csB, 1'b0);
        chk1("mr_queued", rvB, 1'b1);
        cyc();
        rstB_n = 1'b1;
        drvB(1'b0, 10'd0, 1'b0);
        #1;
        chk1("mr_rv_cleared", rvB, 1'b0);
        chk1("mr_gnt_back", gntB, 1'b1);
        cyc();
        for (int k = 0; k < 3; k++) begin
            #1;
            chk1("mr_no_stale", rvB, 1'b0);
            cyc();
        end
        for (int k = 0; k < 4; k++) begin
            drvB(1'b1, 10'(30 + k), 1'b0);
            #1;
            chk1("mr_credit_gnt", gntB, 1'b1);
            cyc();
        end
        drvB(1'b1, 10'd34, 1'b0);
        #1;
        chk1("mr_credit_out", gntB, 1'b0);
        chk("mr_first_rd", rdB, patB(10'd30));
        cyc();
        for (int k = 0; k < 4; k++) begin
            drvB(1'b0, 10'd0, 1'b1);
            #1;
            chk1("mr_rv", rvB, 1'b1);
            chk("mr_rd", rdB, patB(10'(30 + k)));
            cyc();
        end
        #1;
        chk1("mr_drained", rvB, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spram_req_adapter.md
# spram_req_adapter

Request/response front-end that sits directly upstream of the synchronous single-port N x 64-bit byte-enable RAM and drives its chip-select, write-enable, byte-enable, address and write-data pins. It turns a valid/grant request channel into RAM accesses and returns one in-order response per request through a valid/ready channel. Responses wait in a credit-protected FIFO, so the response consumer can stall without losing RAM read data, which is never held by the RAM.

## Interface
Parameters:
- ADDR_WIDTH, 10, RAM word-address width; passed unchanged to RAM.
- RAM_LAT, 1, RAM read latency in cycles: 1 = no RAM output regs, 2 = RAM output regs enabled; legal values 1, 2.
- RESP_DEPTH, 4, response FIFO entries and request credits; legal range 2..16; full throughput needs RESP_DEPTH >= RAM_LAT+2.

Ports:
- Clk_CI  in  1  clock; all logic on rising edge.
- Rst_RBI  in  1  reset, synchronous, active-low.
- Req_SI  in  1  request valid.
- Gnt_SO  out  1  request grant; a request is accepted in a cycle where Req_SI=1 and Gnt_SO=1.
- ReqWe_SI  in  1  1 = write, 0 = read.
- ReqBe_SI  in  8  byte enables, used for writes only.
- ReqAddr_DI  in  ADDR_WIDTH  word address.
- ReqWData_DI  in  64  write data.
- RspValid_SO  out  1  response valid.
- RspReady_SI  in  1  response ready; a response is popped when RspValid_SO=1 and RspReady_SI=1.
- RspWrite_SO  out  1  1 = write acknowledge, 0 = read data.
- RspRData_DO  out  64  read data; 0 for write acknowledges.
- RamCSel_SO, RamWrEn_SO  out  1 each  RAM chip select / write enable.
- RamBEn_SO  out  8  RAM byte enables.
- RamAddr_DO  out  ADDR_WIDTH  RAM address.
- RamWrData_DO  out  64  RAM write data.
- RamRdData_DI  in  64  RAM read data.

## Operation
Credits:
- Credit counter, width clog2(RESP_DEPTH+1), reset value RESP_DEPTH.
- Gnt_SO = (credits != 0) && Rst_RBI.
- Each accept decrements the counter; each pop increments it.
- Accept and pop in the same cycle leave the counter unchanged.
- The counter never underflows or exceeds RESP_DEPTH; the bench checks this with an assertion.

RAM drive (combinational pass-through of the request):
- RamCSel_SO = Req_SI && Gnt_SO.
- RamWrEn_SO = ReqWe_SI && RamCSel_SO.
- RamBEn_SO = ReqBe_SI when RamCSel_SO is high, else 0.
- RamAddr_DO = ReqAddr_DI; RamWrData_DO = ReqWData_DI.

Tag pipeline:
- RAM_LAT stages, each holding {valid, write}; on accept, stage 0 loads {1, ReqWe_SI}; otherwise stage 0 loads {0, 0}.
- When the last stage is valid, the FIFO pushes {write, write ? 64'h0 : RamRdData_DI} in that cycle.
- The last stage is valid exactly when RamRdData_DI belongs to that request.

Response FIFO:
- RESP_DEPTH entries, read/write pointers that wrap at RESP_DEPTH, plus an occupancy count.
- RspValid_SO = (count != 0); RspWrite_SO and RspRData_DO come from the head entry.
- Push and pop in the same cycle: count unchanged, both pointers advance; the push is legal even when the FIFO is full.
- Credits guarantee no push ever reaches a full FIFO without a simultaneous pop.
- Responses leave in acceptance order.

Reset (Rst_RBI=0 at a rising edge):
- Credits return to RESP_DEPTH; pipeline valids, pointers and count clear to 0.
- In-flight requests and queued responses are dropped.
- While Rst_RBI=0: Gnt_SO=0, so RamCSel_SO=0.

Reset values of all outputs:
- Gnt_SO: 0 during reset, 1 in the first cycle after reset.
- RspValid_SO: 0; RspWrite_SO: 0; RspRData_DO: 0 (FIFO storage is not reset, but the output is masked to 0 while empty).
- RAM outputs: 0, except RamAddr_DO and RamWrData_DO, which follow the request inputs.

## Timing
- Request accepted in cycle t: the RAM samples the access at the edge ending cycle t.
- Read data is present at the RAM output during cycle t+RAM_LAT and is pushed at the edge ending that cycle.
- RspValid_SO rises in cycle t+RAM_LAT+1 (response latency RAM_LAT+1).
- A write acknowledge has the same latency.
- A credit freed by a pop in cycle p is usable for a grant in cycle p+1.
- Throughput: one request per cycle sustained when RspReady_SI=1 and RESP_DEPTH >= RAM_LAT+2.
- No combinational path from RspReady_SI to Gnt_SO or to any RAM output.

## Test plan
- Write then read, RAM_LAT=1: write 64'h0123_4567_89AB_CDEF to addr 5 with Be=8'hFF, then read addr 5 -> write-ack response (RspWrite_SO=1, RspRData_DO=0) at cycle t+2; read response with RspRData_DO=64'h0123_4567_89AB_CDEF at cycle t+3.
- Partial write: Be=8'h0F, data 64'hFFFF_FFFF_FFFF_FFFF onto addr 5 holding 64'h0123_4567_89AB_CDEF, then read addr 5 -> RspRData_DO=64'h0123_4567_FFFF_FFFF.
- Backpressure, RAM_LAT=2, RESP_DEPTH=4: RspReady_SI=0 with Req_SI=1 held continuously -> exactly 4 grants, then Gnt_SO=0; raise RspReady_SI -> 4 responses in address order, then Gnt_SO=1 the cycle after the first pop.
- Streaming, RAM_LAT=2, RESP_DEPTH=4, RspReady_SI=1: 100 back-to-back reads of addresses 0..99 -> Gnt_SO stays 1 throughout and exactly 100 responses arrive in order.
- Reset mid-operation: assert Rst_RBI=0 for one cycle while 2 reads are in flight and 1 response is queued -> RspValid_SO=0 the next cycle, no stale response appears afterwards, and credits return to RESP_DEPTH.
- Simultaneous accept and pop with the FIFO full, RESP_DEPTH=2 -> count stays 2, data order preserved, no overflow assertion fires.
